// File: rtl/ps_bc_pkg.sv
// Shared codes for the PS bus-connect select controller: DI/DRR select encodings
// and the ureg address classes that steer the DRR select.
package ps_bc_pkg;

  localparam logic [2:0] DI_DMRD   = 3'b000;
  localparam logic [2:0] DI_STKURG = 3'b001;
  localparam logic [2:0] DI_IMM    = 3'b010;
  localparam logic [2:0] DI_IDLE   = 3'b011;
  localparam logic [2:0] DI_IADD   = 3'b100;

  typedef enum logic [1:0] {
    DRR_00 = 2'b00,
    DRR_01 = 2'b01,
    DRR_10 = 2'b10,
    DRR_11 = 2'b11
  } drr_e;

  localparam int unsigned UR_ZERO   = 0;
  localparam int unsigned UR_DAG0   = 1;
  localparam int unsigned UR_DAG1   = 2;
  localparam int unsigned UR_PCSTK0 = 6;
  localparam int unsigned UR_PCSTK1 = 7;

endpackage

// File: rtl/ps_bc_slct_pipe_if.sv
// Decode-stage bundle between the PS sequencer (master) and the bus-connect
// select controller (slave).
interface ps_bc_slct_pipe_if #(
  parameter int unsigned UREG_AW = 4,
  parameter int unsigned CNT_W   = 3
);
  logic               ps_inst_vld;
  logic               ps_stall;
  logic               ps_flush;
  logic               ps_pshstck;
  logic               ps_popstck;
  logic               ps_imminst;
  logic               ps_dmimminst;
  logic               ps_dmiaddinst;
  logic               ps_dminst;
  logic               ps_urgtrnsinst;
  logic               ps_dm_wrb;
  logic [UREG_AW-1:0] ps_ureg1_add;
  logic [UREG_AW-1:0] ps_ureg2_add;
  logic               ps_stk_clr;
  logic [1:0]         ps_bc_drr_slct;
  logic [2:0]         ps_bc_di_slct;
  logic               ps_bc_vld;
  logic [CNT_W-1:0]   ps_stk_cnt;
  logic               ps_stk_ovf;
  logic               ps_stk_unf;

  modport master (
    output ps_inst_vld, ps_stall, ps_flush, ps_pshstck, ps_popstck, ps_imminst,
           ps_dmimminst, ps_dmiaddinst, ps_dminst, ps_urgtrnsinst, ps_dm_wrb,
           ps_ureg1_add, ps_ureg2_add, ps_stk_clr,
    input  ps_bc_drr_slct, ps_bc_di_slct, ps_bc_vld, ps_stk_cnt, ps_stk_ovf, ps_stk_unf
  );

  modport slave (
    input  ps_inst_vld, ps_stall, ps_flush, ps_pshstck, ps_popstck, ps_imminst,
           ps_dmimminst, ps_dmiaddinst, ps_dminst, ps_urgtrnsinst, ps_dm_wrb,
           ps_ureg1_add, ps_ureg2_add, ps_stk_clr,
    output ps_bc_drr_slct, ps_bc_di_slct, ps_bc_vld, ps_stk_cnt, ps_stk_ovf, ps_stk_unf
  );
endinterface

// File: rtl/ps_bc_ureg_cls.sv
// Maps a ureg address onto the DRR select class of the register file it lives in.
module ps_bc_ureg_cls
  import ps_bc_pkg::*;
#(
  parameter int unsigned UREG_AW = 4
) (
  input  logic [UREG_AW-1:0] ureg_add,
  output drr_e               ureg_cls
);

  always_comb begin
    ureg_cls = DRR_11;
    if (ureg_add == UREG_AW'(UR_ZERO)) begin
      ureg_cls = DRR_10;
    end else if (ureg_add == UREG_AW'(UR_PCSTK0) || ureg_add == UREG_AW'(UR_PCSTK1)) begin
      ureg_cls = DRR_01;
    end else if (ureg_add == UREG_AW'(UR_DAG0) || ureg_add == UREG_AW'(UR_DAG1)) begin
      ureg_cls = DRR_00;
    end
  end

endmodule

// File: rtl/ps_bc_slct_pipe.sv
// PS bus-connect select controller: priority decode of the instruction class into
// DRR/DI selects, parametrised select pipelines, and PC-stack occupancy tracking.
module ps_bc_slct_pipe
  import ps_bc_pkg::*;
#(
  parameter int unsigned UREG_AW   = 4,
  parameter int unsigned DI_LAT    = 1,
  parameter int unsigned DRR_LAT   = 0,
  parameter int unsigned STK_DEPTH = 6,
  localparam int unsigned CNT_W    = $clog2(STK_DEPTH + 1)
) (
  input logic              clk_dcd,
  input logic              reset,
  ps_bc_slct_pipe_if.slave bus
);

  drr_e       cls1, cls2;
  logic [2:0] dec_di;
  drr_e       dec_drr;
  logic       dec_vld;
  logic       push_win, pop_win;
  logic       dm_any;

  ps_bc_ureg_cls #(.UREG_AW(UREG_AW)) u_cls1 (.ureg_add(bus.ps_ureg1_add), .ureg_cls(cls1));
  ps_bc_ureg_cls #(.UREG_AW(UREG_AW)) u_cls2 (.ureg_add(bus.ps_ureg2_add), .ureg_cls(cls2));

  assign dm_any = bus.ps_dminst | bus.ps_dmiaddinst;

  always_comb begin
    dec_di   = DI_IDLE;
    dec_drr  = DRR_11;
    dec_vld  = 1'b0;
    push_win = 1'b0;
    pop_win  = 1'b0;
    if (bus.ps_inst_vld) begin
      dec_vld = 1'b1;
      if (bus.ps_imminst | bus.ps_dmimminst) begin
        dec_di = DI_IMM;
      end else if (bus.ps_popstck) begin
        dec_di  = DI_STKURG;
        dec_drr = DRR_01;
        pop_win = 1'b1;
      end else if (dm_any & ~bus.ps_dm_wrb) begin
        dec_di = DI_DMRD | (bus.ps_dmiaddinst ? DI_IADD : 3'b000);
      end else if ((dm_any & bus.ps_dm_wrb) | bus.ps_pshstck) begin
        dec_di   = DI_STKURG | (bus.ps_dmiaddinst ? DI_IADD : 3'b000);
        dec_drr  = cls1;
        // A DM write may coincide with a push; only the push moves the stack.
        push_win = bus.ps_pshstck;
      end else if (bus.ps_urgtrnsinst) begin
        dec_di  = DI_STKURG;
        dec_drr = cls2;
      end else begin
        dec_vld = 1'b0;
      end
    end
  end

  // DI select and valid bit travel together through DI_LAT stages.
  for (genvar g = 0; g < DI_LAT; g++) begin : g_di
    logic [2:0] di_d, di_q;
    logic       vld_d, vld_q;
    if (g == 0) begin : g_head
      assign di_d  = dec_di;
      assign vld_d = dec_vld;
    end else begin : g_tail
      assign di_d  = g_di[g-1].di_q;
      assign vld_d = g_di[g-1].vld_q;
    end
    always_ff @(posedge clk_dcd or posedge reset) begin
      if (reset) begin
        di_q  <= DI_IDLE;
        vld_q <= 1'b0;
      end else if (bus.ps_flush) begin
        di_q  <= DI_IDLE;
        vld_q <= 1'b0;
      end else if (!bus.ps_stall) begin
        di_q  <= di_d;
        vld_q <= vld_d;
      end
    end
  end

  assign bus.ps_bc_di_slct = g_di[DI_LAT-1].di_q;
  assign bus.ps_bc_vld     = g_di[DI_LAT-1].vld_q;

  if (DRR_LAT == 0) begin : g_drr_comb
    assign bus.ps_bc_drr_slct = dec_drr;
  end else begin : g_drr_pipe
    for (genvar g = 0; g < DRR_LAT; g++) begin : g_drr
      drr_e drr_d, drr_q;
      if (g == 0) begin : g_head
        assign drr_d = dec_drr;
      end else begin : g_tail
        assign drr_d = g_drr[g-1].drr_q;
      end
      always_ff @(posedge clk_dcd or posedge reset) begin
        if (reset) begin
          drr_q <= DRR_11;
        end else if (bus.ps_flush) begin
          drr_q <= DRR_11;
        end else if (!bus.ps_stall) begin
          drr_q <= drr_d;
        end
      end
    end
    assign bus.ps_bc_drr_slct = g_drr[DRR_LAT-1].drr_q;
  end

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, unf_q;

  // Clear is applied first so an event in the same cycle keeps its flag set.
  always_ff @(posedge clk_dcd or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.ps_stk_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (!bus.ps_stall && !bus.ps_flush) begin
        if (pop_win) begin
          if (cnt_q == '0) unf_q <= 1'b1;
          else             cnt_q <= cnt_q - CNT_W'(1);
        end else if (push_win) begin
          if (cnt_q == CNT_W'(STK_DEPTH)) ovf_q <= 1'b1;
          else                            cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.ps_stk_cnt = cnt_q;
  assign bus.ps_stk_ovf = ovf_q;
  assign bus.ps_stk_unf = unf_q;

endmodule
